// File: rtl/load_align_extend.sv
// rtl/load_align_extend.sv - registered load-data align/extend with a 2-entry skid buffer
// Optional misaligned-load trap is enabled by defining LOAD_MISALIGN_TRAP_EN.
module load_align_extend #(
    parameter int DATA_WIDTH = 32,
    parameter int OFFS_WIDTH = $clog2(DATA_WIDTH/8)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [OFFS_WIDTH-1:0] i_byte_offset,
    input  logic [1:0]            i_size,
    input  logic                  i_is_signed,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data
`ifdef LOAD_MISALIGN_TRAP_EN
    ,
    output logic                  o_misaligned
`endif
);

    localparam int         LG_NB  = $clog2(DATA_WIDTH/8);
    localparam int         IW     = $clog2(DATA_WIDTH);
    localparam logic [2:0] LG_MAX = 3'(LG_NB);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    logic [2:0]            lg_b;
    logic [OFFS_WIDTH-1:0] low_mask;
    logic [OFFS_WIDTH-1:0] aligned_offs;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] fmt_data;
    logic [7:0]            w_bits;
    logic [IW-1:0]         sign_idx;
    logic                  sign_bit;

    // Field size is clamped to the beat width, so a full-width field has an
    // all-ones mask and no extension bits.
    always_comb begin
        lg_b         = ({1'b0, i_size} > LG_MAX) ? LG_MAX : {1'b0, i_size};
        low_mask     = ~({OFFS_WIDTH{1'b1}} << lg_b);
        aligned_offs = i_byte_offset & ~low_mask;
        shifted      = i_data >> {aligned_offs, 3'b000};
        w_bits       = 8'd8 << lg_b;
        wmask        = ~({DATA_WIDTH{1'b1}} << w_bits);
        sign_idx     = IW'(w_bits - 8'd1);
        sign_bit     = i_is_signed & shifted[sign_idx];
        fmt_data     = (shifted & wmask) | ({DATA_WIDTH{sign_bit}} & ~wmask);
`ifdef LOAD_MISALIGN_TRAP_EN
        if (|(i_byte_offset & low_mask)) begin
            fmt_data = '0;
        end
`endif
    end

`ifdef LOAD_MISALIGN_TRAP_EN
    logic fmt_mis;
    logic main_mis_q;
    logic skid_mis_q;

    assign fmt_mis      = |(i_byte_offset & low_mask);
    assign o_misaligned = main_mis_q;
`endif

    state_t                state_q;
    logic                  rdy_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  accept;
    logic                  drain;

    // Ready comes from registered state only; the reset term forces it low
    // during the reset cycle itself.
    assign o_ready = rdy_q & i_reset_n;
    assign o_valid = valid_q;
    assign o_data  = main_q;
    assign accept  = i_valid & o_ready;
    assign drain   = valid_q & i_ready;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b0;
            valid_q <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            rdy_q <= 1'b1;
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_q  <= fmt_data;
                        valid_q <= 1'b1;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (accept && !drain) begin
                        skid_q  <= fmt_data;
                        rdy_q   <= 1'b0;
                        state_q <= FULL;
                    end else if (accept) begin
                        main_q  <= fmt_data;
                    end else if (drain) begin
                        valid_q <= 1'b0;
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        main_q  <= skid_q;
                        state_q <= ONE;
                    end else begin
                        rdy_q   <= 1'b0;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= EMPTY;
                end
            endcase
        end
    end

`ifdef LOAD_MISALIGN_TRAP_EN
    // Trap flag travels with its beat through the same main/skid slots.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            main_mis_q <= 1'b0;
            skid_mis_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: if (accept) main_mis_q <= fmt_mis;
                ONE: begin
                    if (accept && !drain) begin
                        skid_mis_q <= fmt_mis;
                    end else if (accept) begin
                        main_mis_q <= fmt_mis;
                    end
                end
                FULL: if (drain) main_mis_q <= skid_mis_q;
                default: main_mis_q <= 1'b0;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_load_align_extend.sv
// tb/tb_load_align_extend.sv - self-checking bench for load_align_extend (DATA_WIDTH=32)
module tb_load_align_extend;

    localparam int DW = 32;

    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic [1:0]    i_byte_offset = '0;
    logic [1:0]    i_size = '0;
    logic          i_is_signed = 1'b0;
    logic          i_ready = 1'b0;
    logic          o_ready;
    logic          o_valid;
    logic [DW-1:0] o_data;
`ifdef LOAD_MISALIGN_TRAP_EN
    logic          o_misaligned;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [32:0] mq[$];
    bit          m_rdy = 1'b0;
    bit          checking = 1'b0;
    bit          m_acc;
    bit          m_drn;
    logic [31:0] drained[$];
    int          drain_cyc[$];

    always #5 i_clk = ~i_clk;

    load_align_extend #(.DATA_WIDTH(DW)) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_data        (i_data),
        .i_byte_offset (i_byte_offset),
        .i_size        (i_size),
        .i_is_signed   (i_is_signed),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data)
`ifdef LOAD_MISALIGN_TRAP_EN
        ,
        .o_misaligned  (o_misaligned)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int field_bytes(input int size);
        int w;
        w = 8 << size;
        if (w > DW) w = DW;
        return w / 8;
    endfunction

    function automatic bit is_mis(input int off, input int size);
        return (off % field_bytes(size)) != 0;
    endfunction

    function automatic logic [31:0] fmt(input logic [31:0] d, input int off, input int size, input bit sgn);
        int b, w, a;
        logic [63:0] f, m;
        b = field_bytes(size);
        w = 8 * b;
        a = off - (off % b);
        m = (64'd1 << w) - 64'd1;
        f = ({32'd0, d} >> (8 * a)) & m;
        if (sgn && w < DW && f[w-1]) f = f | ~m;
`ifdef LOAD_MISALIGN_TRAP_EN
        if (is_mis(off, size)) f = '0;
`endif
        return f[31:0];
    endfunction

    // Reference: a capacity-2 FIFO of formatted beats
    always @(posedge i_clk) begin
        cyc++;
        if (!i_reset_n) begin
            mq.delete();
            m_rdy = 1'b0;
        end else begin
            m_acc = i_valid && m_rdy && (mq.size() < 2);
            m_drn = (mq.size() > 0) && i_ready;
            if (m_drn) void'(mq.pop_front());
            if (m_acc) mq.push_back({is_mis(i_byte_offset, i_size),
                                     fmt(i_data, i_byte_offset, i_size, i_is_signed)});
            m_rdy = 1'b1;
        end
        checking = 1'b1;
    end

    always @(negedge i_clk) begin
        if (checking) begin
            chk("o_valid", o_valid, mq.size() > 0);
            chk("o_ready", o_ready, m_rdy && (mq.size() < 2) && i_reset_n);
            if (mq.size() > 0) begin
                chk("o_data", o_data, mq[0][31:0]);
`ifdef LOAD_MISALIGN_TRAP_EN
                chk("o_misaligned", o_misaligned, mq[0][32]);
`endif
            end
            if (o_valid && i_ready) begin
                drained.push_back(o_data);
                drain_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input int off, input int sz, input bit sg);
        bit ok;
        int n;
        n = 0;
        i_valid = 1'b1;
        i_data = d;
        i_byte_offset = 2'(off);
        i_size = 2'(sz);
        i_is_signed = sg;
        do begin
            @(negedge i_clk);
            ok = o_ready;
            tick();
            n++;
        end while (!ok && n < 50);
        chk("send_accept", ok, 1);
        i_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [31:0] exp);
        @(negedge i_clk);
        chk({name, "_valid"}, o_valid, 1);
        chk(name, o_data, exp);
        tick();
    endtask

    typedef struct {
        logic [31:0] d;
        int          off;
        int          sz;
        bit          sg;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bit ok;
        int n;
        int base;

        // Pin the reference against hand-computed values
        chk("model_byte_s", fmt(32'h123480FF, 1, 0, 1), 32'hFFFFFF80);
        chk("model_byte_u", fmt(32'h123480FF, 1, 0, 0), 32'h00000080);
        chk("model_half_u", fmt(32'h80010000, 2, 1, 0), 32'h00008001);
        chk("model_half_s", fmt(32'h80010000, 2, 1, 1), 32'hFFFF8001);
`ifdef LOAD_MISALIGN_TRAP_EN
        chk("model_mis", fmt(32'hAABBCCDD, 1, 1, 1), 32'h00000000);
`else
        chk("model_mis", fmt(32'hAABBCCDD, 1, 1, 1), 32'hFFFFCCDD);
`endif

        // 1: reset with i_valid asserted
        i_reset_n = 1'b0;
        i_valid = 1'b1;
        i_data = 32'hCAFEF00D;
        repeat (2) tick();
        @(negedge i_clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_ready", o_ready, 0);
        tick();
        i_reset_n = 1'b1;
        i_valid = 1'b0;
        tick();
        @(negedge i_clk);
        chk("ready_after_release", o_ready, 1);
        tick();

        // 2, 3: byte and half extraction
        i_ready = 1'b1;
        send(32'h123480FF, 1, 0, 1); expect_out("byte_s", 32'hFFFFFF80);
        send(32'h123480FF, 1, 0, 0); expect_out("byte_u", 32'h00000080);
        send(32'h80010000, 2, 1, 0); expect_out("half_u", 32'h00008001);
        send(32'h80010000, 2, 1, 1); expect_out("half_s", 32'hFFFF8001);

        vecs.push_back('{32'hAABBCCDD, 3, 0, 1'b1, 32'hFFFFFFAA});
        vecs.push_back('{32'hAABBCCDD, 2, 0, 1'b0, 32'h000000BB});
        vecs.push_back('{32'h8000FFFF, 0, 2, 1'b1, 32'h8000FFFF});
        vecs.push_back('{32'hF0000001, 0, 3, 1'b0, 32'hF0000001});
        vecs.push_back('{32'h7FFF8000, 0, 1, 1'b1, 32'hFFFF8000});
        vecs.push_back('{32'h7FFF8000, 2, 1, 1'b1, 32'h00007FFF});
        foreach (vecs[i]) begin
            send(vecs[i].d, vecs[i].off, vecs[i].sz, vecs[i].sg);
            expect_out("vec", vecs[i].exp);
        end

        // 5: misaligned half
        send(32'hAABBCCDD, 1, 1, 1);
`ifdef LOAD_MISALIGN_TRAP_EN
        @(negedge i_clk);
        chk("mis_flag", o_misaligned, 1);
        tick();
        send(32'h12345678, 3, 3, 0); expect_out("dword_off3", 32'h00000000);
`else
        expect_out("mis_half", 32'hFFFFCCDD);
        send(32'h12345678, 3, 3, 0); expect_out("dword_off3", 32'h12345678);
`endif

        // 4: backpressure fills both slots, then drains in order
        i_ready = 1'b0;
        tick();
        send(32'h11, 0, 0, 0);
        send(32'h22, 0, 0, 0);
        @(negedge i_clk);
        chk("full_ready", o_ready, 0);
        tick();
        i_valid = 1'b1;
        i_data = 32'h33;
        repeat (3) begin
            @(negedge i_clk);
            chk("held_ready", o_ready, 0);
            chk("held_data", o_data, 32'h11);
            tick();
        end
        base = drained.size();
        i_ready = 1'b1;
        n = 0;
        do begin
            @(negedge i_clk);
            ok = o_ready;
            tick();
            n++;
        end while (!ok && n < 50);
        chk("third_accept", ok, 1);
        i_valid = 1'b0;
        repeat (3) tick();
        chk("drain_count", drained.size() >= base + 3, 1);
        if (drained.size() >= base + 3) begin
            chk("drain0", drained[base], 32'h11);
            chk("drain1", drained[base+1], 32'h22);
            chk("drain2", drained[base+2], 32'h33);
            chk("drain_gap1", drain_cyc[base+1] - drain_cyc[base], 1);
            chk("drain_gap2", drain_cyc[base+2] - drain_cyc[base+1], 1);
        end

        // 6: reset while FULL
        i_ready = 1'b0;
        send(32'h44, 0, 0, 0);
        send(32'h55, 0, 0, 0);
        i_reset_n = 1'b0;
        @(negedge i_clk);
        chk("rst_pulse_ready", o_ready, 0);
        tick();
        i_reset_n = 1'b1;
        i_ready = 1'b1;
        @(negedge i_clk);
        chk("rst_pulse_valid", o_valid, 0);
        chk("rst_pulse_data", o_data, 0);
        tick();
        send(32'hDEADBEEF, 0, 2, 0);
        expect_out("post_reset_word", 32'hDEADBEEF);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
